// File: rtl/regfile_write_arbiter.sv
// Dual-port register-file write arbiter: three requesters compete for two write slots, with round-robin and aging priority.
// Latency: gnt is combinational in the request cycle; we/waddr/wdata are registered and appear one cycle after the grant.
// Backpressure: a requester holds req/addr/data until its gnt cycle; same-address collisions and a third request simply wait.
module regfile_write_arbiter #(
    parameter int AGE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [3:0]  addr0,
    input  logic [3:0]  addr1,
    input  logic [3:0]  addr2,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  gnt,
    output logic        we,
    output logic        we2,
    output logic [3:0]  waddr1,
    output logic [3:0]  waddr2,
    output logic [15:0] wdata1,
    output logic [15:0] wdata2
);

    // Modulo-3 increment; rr_ptr never takes the value 3.
    function automatic logic [1:0] f_inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    logic [1:0]  r_rr_ptr;
    logic [2:0]  r_age [3];
    logic        r_we;
    logic        r_we2;
    logic [3:0]  r_waddr1;
    logic [3:0]  r_waddr2;
    logic [15:0] r_wdata1;
    logic [15:0] r_wdata2;

    logic [3:0]  w_addr [3];
    logic [15:0] w_data [3];
    logic [1:0]  w_rr [3];
    logic [1:0]  w_ord [3];
    logic        w_aged_vld;
    logic [1:0]  w_aged_idx;
    logic        w_s1_vld;
    logic [1:0]  w_s1_idx;
    logic        w_s2_vld;
    logic [1:0]  w_s2_idx;
    logic [1:0]  w_last_idx;

    assign w_addr[0] = addr0;
    assign w_addr[1] = addr1;
    assign w_addr[2] = addr2;
    assign w_data[0] = data0;
    assign w_data[1] = data1;
    assign w_data[2] = data2;

    assign w_rr[0] = r_rr_ptr;
    assign w_rr[1] = f_inc3(r_rr_ptr);
    assign w_rr[2] = f_inc3(f_inc3(r_rr_ptr));

    // Find the lowest-index requester whose wait count has hit the aging limit.
    always_comb begin
        w_aged_vld = 1'b0;
        w_aged_idx = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (int'(r_age[i]) >= AGE_LIMIT) begin
                w_aged_vld = 1'b1;
                w_aged_idx = 2'(i);
            end
        end
    end

    // Priority order: round-robin from rr_ptr, with an aged requester pulled to the front
    // and the other two keeping their relative round-robin order.
    always_comb begin
        w_ord[0] = w_rr[0];
        w_ord[1] = w_rr[1];
        w_ord[2] = w_rr[2];
        if (w_aged_vld) begin
            if (w_aged_idx == w_rr[1]) begin
                w_ord[0] = w_rr[1];
                w_ord[1] = w_rr[0];
                w_ord[2] = w_rr[2];
            end else if (w_aged_idx == w_rr[2]) begin
                w_ord[0] = w_rr[2];
                w_ord[1] = w_rr[0];
                w_ord[2] = w_rr[1];
            end
        end
    end

    // Slot 1 takes the first asserted requester; slot 2 the next one whose address
    // differs from slot 1, so the two write ports never target the same register.
    always_comb begin
        w_s1_vld = 1'b0;
        w_s1_idx = 2'd0;
        w_s2_vld = 1'b0;
        w_s2_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (req[w_ord[k]] && !w_s1_vld) begin
                w_s1_vld = 1'b1;
                w_s1_idx = w_ord[k];
            end else if (req[w_ord[k]] && w_s1_vld && !w_s2_vld &&
                         (w_addr[w_ord[k]] != w_addr[w_s1_idx])) begin
                w_s2_vld = 1'b1;
                w_s2_idx = w_ord[k];
            end
        end
        if (rst) begin
            w_s1_vld = 1'b0;
            w_s2_vld = 1'b0;
        end
    end

    assign w_last_idx = w_s2_vld ? w_s2_idx : w_s1_idx;

    // Decode the two slot selections into the one-hot-per-requester grant vector.
    always_comb begin
        gnt = 3'b000;
        if (w_s1_vld) gnt[w_s1_idx] = 1'b1;
        if (w_s2_vld) gnt[w_s2_idx] = 1'b1;
    end

    // Advance the round-robin pointer past the last requester granted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 2'd0;
        end else if (w_s1_vld) begin
            r_rr_ptr <= f_inc3(w_last_idx);
        end
    end

    // Wait counters: count cycles spent requesting without a grant, saturating at 7.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                r_age[i] <= 3'd0;
            end else if (req[i] && !gnt[i]) begin
                r_age[i] <= (r_age[i] == 3'd7) ? 3'd7 : r_age[i] + 3'd1;
            end else begin
                r_age[i] <= 3'd0;
            end
        end
    end

    // Write port 1: pulse we for each slot-1 grant; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_waddr1 <= 4'd0;
            r_wdata1 <= 16'd0;
        end else begin
            r_we <= w_s1_vld;
            if (w_s1_vld) begin
                r_waddr1 <= w_addr[w_s1_idx];
                r_wdata1 <= w_data[w_s1_idx];
            end
        end
    end

    // Write port 2: pulse we2 for each slot-2 grant; address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we2    <= 1'b0;
            r_waddr2 <= 4'd0;
            r_wdata2 <= 16'd0;
        end else begin
            r_we2 <= w_s2_vld;
            if (w_s2_vld) begin
                r_waddr2 <= w_addr[w_s2_idx];
                r_wdata2 <= w_data[w_s2_idx];
            end
        end
    end

    // Reset also masks the outputs combinationally, so a write granted just before
    // reset rises never reaches the register file.
    assign we     = r_we & ~rst;
    assign we2    = r_we2 & ~rst;
    assign waddr1 = rst ? 4'd0 : r_waddr1;
    assign waddr2 = rst ? 4'd0 : r_waddr2;
    assign wdata1 = rst ? 16'd0 : r_wdata1;
    assign wdata2 = rst ? 16'd0 : r_wdata2;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed grants and writes.
// Latency: gnt checked in the request cycle, write outputs checked #1 after the following edge.
// Backpressure: requesters hold req/addr/data until granted, as the handshake requires.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [3:0]  addr0, addr1, addr2;
    logic [15:0] data0, data1, data2;
    logic [2:0]  gnt;
    logic        we, we2;
    logic [3:0]  waddr1, waddr2;
    logic [15:0] wdata1, wdata2;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.AGE_LIMIT(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .addr0  (addr0),
        .addr1  (addr1),
        .addr2  (addr2),
        .data0  (data0),
        .data1  (data1),
        .data2  (data2),
        .gnt    (gnt),
        .we     (we),
        .we2    (we2),
        .waddr1 (waddr1),
        .waddr2 (waddr2),
        .wdata1 (wdata1),
        .wdata2 (wdata2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a request vector, check the combinational grant, then clock it in.
    task automatic step(input string tag, input logic [2:0] r, input logic [2:0] g_exp);
        req = r;
        #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'(g_exp));
        tick();
    endtask

    task automatic chk_wr(input string tag, input logic e1, input logic [3:0] a1,
                          input logic [15:0] d1, input logic e2, input logic [3:0] a2,
                          input logic [15:0] d2);
        chk({tag, "_we"},     32'(we),     32'(e1));
        chk({tag, "_waddr1"}, 32'(waddr1), 32'(a1));
        chk({tag, "_wdata1"}, 32'(wdata1), 32'(d1));
        chk({tag, "_we2"},    32'(we2),    32'(e2));
        chk({tag, "_waddr2"}, 32'(waddr2), 32'(a2));
        chk({tag, "_wdata2"}, 32'(wdata2), 32'(d2));
    endtask

    initial begin
        rst = 1'b1;
        req = 3'b000;
        addr0 = 4'd0; addr1 = 4'd0; addr2 = 4'd0;
        data0 = 16'h0; data1 = 16'h0; data2 = 16'h0;

        // Reset state, and no grants while reset is held even with all requesting.
        tick();
        chk_wr("rst", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        addr0 = 4'd1; addr1 = 4'd2; addr2 = 4'd3;
        req = 3'b111;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        tick();
        chk_wr("rst2", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);

        // Two distinct addresses from rr_ptr=0: both slots granted.
        rst = 1'b0;
        addr0 = 4'd2; data0 = 16'h1234; addr1 = 4'd5; data1 = 16'hABCD;
        step("dual", 3'b011, 3'b011);
        chk_wr("dual", 1'b1, 4'd2, 16'h1234, 1'b1, 4'd5, 16'hABCD);
        chk("dual_ptr", 32'(dut.r_rr_ptr), 32'd2);

        // Single grant to requester 2: port 2 holds, pointer wraps to 0.
        addr2 = 4'd4; data2 = 16'h0404;
        step("single2", 3'b100, 3'b100);
        chk_wr("single2", 1'b1, 4'd4, 16'h0404, 1'b0, 4'd5, 16'hABCD);

        // Three distinct addresses: two granted, third waits one cycle.
        addr0 = 4'd1; data0 = 16'h1111; addr1 = 4'd2; data1 = 16'h2222;
        addr2 = 4'd3; data2 = 16'h3333;
        step("three_a", 3'b111, 3'b011);
        chk_wr("three_a", 1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222);
        step("three_b", 3'b100, 3'b100);
        chk_wr("three_b", 1'b1, 4'd3, 16'h3333, 1'b0, 4'd2, 16'h2222);
        chk("three_ptr", 32'(dut.r_rr_ptr), 32'd0);

        // Same address on both requesters: only one slot per cycle.
        addr0 = 4'd7; data0 = 16'h7000; addr1 = 4'd7; data1 = 16'h7001;
        step("same_a", 3'b011, 3'b001);
        chk_wr("same_a", 1'b1, 4'd7, 16'h7000, 1'b0, 4'd2, 16'h2222);
        step("same_b", 3'b010, 3'b010);
        chk_wr("same_b", 1'b1, 4'd7, 16'h7001, 1'b0, 4'd2, 16'h2222);

        // Write to register 3 (rr_ptr=2, order 2,0,1), then idle five cycles.
        addr0 = 4'd3; data0 = 16'h0333;
        step("wr3", 3'b001, 3'b001);
        chk_wr("wr3", 1'b1, 4'd3, 16'h0333, 1'b0, 4'd2, 16'h2222);
        for (int c = 0; c < 5; c++) begin
            step("idle", 3'b000, 3'b000);
            chk_wr("idle", 1'b0, 4'd3, 16'h0333, 1'b0, 4'd2, 16'h2222);
        end
        chk("idle_ptr", 32'(dut.r_rr_ptr), 32'd1);

        // Starvation pattern at rr_ptr=1: requester 2 shares requester 1's address and
        // requester 0 keeps taking slot 2, so the pointer stays at 1 until aging kicks in.
        addr0 = 4'd8; data0 = 16'h0800; addr1 = 4'd9; data1 = 16'h0901;
        addr2 = 4'd9; data2 = 16'h0902;
        for (int c = 0; c < 4; c++) begin
            step("age_hold", 3'b111, 3'b011);
            chk_wr("age_hold", 1'b1, 4'd9, 16'h0901, 1'b1, 4'd8, 16'h0800);
        end
        step("age_promote", 3'b111, 3'b101);
        chk_wr("age_promote", 1'b1, 4'd9, 16'h0902, 1'b1, 4'd8, 16'h0800);

        // All three on address 9: only one grant per cycle, requester 2 served quickly.
        addr0 = 4'd9; data0 = 16'h0900;
        step("addr9_a", 3'b111, 3'b010);
        chk_wr("addr9_a", 1'b1, 4'd9, 16'h0901, 1'b0, 4'd8, 16'h0800);
        step("addr9_b", 3'b111, 3'b100);
        chk_wr("addr9_b", 1'b1, 4'd9, 16'h0902, 1'b0, 4'd8, 16'h0800);

        // Grant, then reset for one cycle: the pending write pulse is suppressed.
        addr0 = 4'd6; data0 = 16'h0606;
        step("pre_rst", 3'b001, 3'b001);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk_wr("mid_rst", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        tick();
        chk_wr("mid_rst_reg", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);

        // First cycle after reset arbitrates from rr_ptr=0 with zero ages.
        rst = 1'b0;
        addr1 = 4'd10; data1 = 16'h0A0A; addr2 = 4'd11; data2 = 16'h0B0B;
        req = 3'b111;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'b011);
        chk("post_rst_we", 32'(we), 32'h0);
        tick();
        chk_wr("post_rst", 1'b1, 4'd6, 16'h0606, 1'b1, 4'd10, 16'h0A0A);

        req = 3'b000;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter AGE_LIMIT, default 4: wait-cycle count at which a requester is promoted to top priority.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  3  write request, one bit per requester 0..2.
REQ-005 addr0, addr1, addr2  input  4 each  destination register of requester n.
REQ-006 data0, data1, data2  input  16 each  write data of requester n.
REQ-007 gnt  output  3  combinational grant, one bit per requester.
REQ-008 we  output  1  registered register-file write enable, port 1.
REQ-009 we2  output  1  registered enable for second write port.
REQ-010 waddr1, waddr2  output  4 each  registered write addresses.
REQ-011 wdata1, wdata2  output  16 each  registered write data.

Function
REQ-012 Handshake: requester n SHALL hold req[n], addrn and datan stable until the cycle gnt[n]=1; a request is consumed in its grant cycle.
REQ-013 gnt SHALL be all zero while rst=1 and SHALL satisfy gnt[n] -> req[n].
REQ-014 Priority order SHALL be rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); rr_ptr is 2 bits, legal values 0..2.
REQ-015 Aging override: if any wait counter >= AGE_LIMIT, the lowest-index such requester SHALL be first in the order; remaining order unchanged from REQ-014.
REQ-016 Slot 1 SHALL go to the first asserted requester in the order.
REQ-017 Slot 2 SHALL go to the next asserted requester whose address differs from slot 1's address; same-address requesters are not granted that cycle.
REQ-018 At most two gnt bits SHALL be set per cycle; with three distinct-address requests, the third waits.
REQ-019 Latency: one cycle; the edge after a grant, we=1, waddr1/wdata1 = slot 1 fields; if slot 2 granted, we2=1, waddr2/wdata2 = slot 2 fields.
REQ-020 No grant in a cycle -> next cycle we=0, we2=0; waddr/wdata hold previous values.
REQ-021 Slot 1 only -> next cycle we=1, we2=0, waddr2/wdata2 hold.
REQ-022 we2=1 SHALL never occur with we=0, and waddr1 != waddr2 whenever we2=1.
REQ-023 After any grant, rr_ptr SHALL become (index of last-granted slot + 1) mod 3; no grant -> rr_ptr unchanged.
REQ-024 Per-requester 3-bit wait counter: +1 when req[n]=1 and gnt[n]=0, saturating at 7; cleared when gnt[n]=1 or req[n]=0.
REQ-025 Dropping req[n] without a grant is legal; counter clears, no write issued.

Reset
REQ-026 While rst=1 at an edge: we=0, we2=0, waddr1=waddr2=0, wdata1=wdata2=0, rr_ptr=0, all wait counters=0.
REQ-027 Reset mid-operation: requests pending in the reset cycle SHALL be neither granted nor written; a grant issued the cycle before rst rises SHALL have its we/we2 pulse suppressed (outputs forced to reset values).
REQ-028 First cycle after rst falls SHALL arbitrate from rr_ptr=0 with zero ages.

Verification
REQ-029 Reset, then req=3'b011, addr0=2, data0=16'h1234, addr1=5, data1=16'hABCD -> gnt=3'b011; next cycle we=1, waddr1=2, wdata1=16'h1234, we2=1, waddr2=5, wdata2=16'hABCD; rr_ptr=2.
REQ-030 rr_ptr=0, req=3'b111 all distinct addresses held -> cycle1 gnt=3'b011, cycle2 gnt=3'b100 (with only req2 left), rr_ptr=0 afterwards.
REQ-031 req=3'b011, addr0=addr1=7 -> gnt=3'b001, next cycle we=1, we2=0, waddr1=7; following cycle gnt=3'b010, waddr1=7 with data1.
REQ-032 Aging: requester 2 held with addr=9 while requesters 0 and 1 re-request every cycle on addr=9 -> requester 2 granted no later than the cycle its counter reaches 4; gnt never 3'b011 or 3'b110 on same address.
REQ-033 rst asserted for one cycle the cycle after a grant with req=3'b001 held -> we=0, outputs 0 that cycle; first post-reset cycle gnt=3'b001, write issued one cycle later.
REQ-034 Idle req=3'b000 for 5 cycles after a write to register 3 -> we=0, we2=0 every cycle, waddr1 remains 3, rr_ptr unchanged.
